wb_sram_rr_arbiter: RTL

// Two-initiator round-robin Wishbone arbiter for the single-port SoC SRAM target.

---
 rtl/wb_sram_rr_arbiter_pkg.sv | 49 ++++
 rtl/wb_sram_rr_arbiter_watchdog.sv | 50 +++++
 rtl/wb_sram_rr_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_rr_arbiter_pkg.sv
// Shared definitions for the two-initiator Wishbone SRAM arbiter:
// FSM state encodings, one-hot grant codes, the request bundle that is
// muxed towards the SRAM, and a state-to-grant decode helper.
package wb_sram_rr_arbiter_pkg;

    // Arbiter FSM state encodings
    localparam logic [1:0] WB_ARB_IDLE = 2'd0;
    localparam logic [1:0] WB_ARB_OWN0 = 2'd1;
    localparam logic [1:0] WB_ARB_OWN1 = 2'd2;

    // One-hot grant codes, bit order {m1, m0}
    localparam logic [1:0] WB_GNT_NONE = 2'b00;
    localparam logic [1:0] WB_GNT_M0   = 2'b01;
    localparam logic [1:0] WB_GNT_M1   = 2'b10;

    // Initiator request bundle forwarded to the SRAM target
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wb_req_t;

    // All-zero request used whenever nobody owns the bus
    function automatic wb_req_t wb_req_idle();
        wb_req_t req;
        req.cyc = 1'b0;
        req.stb = 1'b0;
        req.we  = 1'b0;
        req.adr = 32'd0;
        req.sel = 4'd0;
        req.dat = 32'd0;
        return req;
    endfunction

    // Decode the FSM state into the one-hot grant vector
    function automatic logic [1:0] state_to_grant(input logic [1:0] state);
        logic [1:0] gnt;
        case (state)
            WB_ARB_OWN0: gnt = WB_GNT_M0;
            WB_ARB_OWN1: gnt = WB_GNT_M1;
            default:     gnt = WB_GNT_NONE;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/wb_sram_rr_arbiter_watchdog.sv
// Per-access watchdog for the SRAM arbiter.
// Counts cycles in which the owner strobes without an ack/err. When the
// count reaches TIMEOUT_CYCLES-1 while still stalled, fire_o pulses high for
// exactly one cycle and the counter restarts. TIMEOUT_CYCLES=0 disables it.
module wb_sram_rr_arbiter_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_CNT_W  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic fire_o
);

    localparam int unsigned LP_LAST_INT = (TIMEOUT_CYCLES > 32'd0) ? (TIMEOUT_CYCLES - 32'd1) : 32'd0;
    localparam logic [TIMEOUT_CNT_W-1:0] LP_LAST = TIMEOUT_CNT_W'(LP_LAST_INT);
    localparam logic [TIMEOUT_CNT_W-1:0] LP_SAT  = TIMEOUT_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_CNT_W-1:0] LP_ONE  = TIMEOUT_CNT_W'(32'd1);
    localparam logic [TIMEOUT_CNT_W-1:0] LP_ZERO = TIMEOUT_CNT_W'(32'd0);
    localparam logic LP_ENABLED = (TIMEOUT_CYCLES != 32'd0);

    logic [TIMEOUT_CNT_W-1:0] r_cnt;
    logic                     r_fire;

    // Stall counter with saturation and single-cycle fire pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= LP_ZERO;
            r_fire <= 1'b0;
        end else if (!LP_ENABLED || clear || !enable) begin
            // disabled, ownership change, or the access made progress
            r_cnt  <= LP_ZERO;
            r_fire <= 1'b0;
        end else if (r_cnt == LP_LAST) begin
            r_cnt  <= LP_ZERO;
            r_fire <= 1'b1;
        end else if (r_cnt < LP_SAT) begin
            r_cnt  <= r_cnt + LP_ONE;
            r_fire <= 1'b0;
        end else begin
            // saturated: hold, never wrap
            r_cnt  <= r_cnt;
            r_fire <= 1'b0;
        end
    end

    assign fire_o = r_fire;

endmodule

// File: rtl/wb_sram_rr_arbiter.sv
// Two-initiator round-robin Wishbone arbiter in front of the single-port
// SoC SRAM. m0 is the CPU data port, m1 the secondary initiator. Ownership
// is held while the owner keeps cyc high; ties from IDLE go to the initiator
// that did not own the bus last. A watchdog returns err to a stalled owner.
module wb_sram_rr_arbiter
    import wb_sram_rr_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_CNT_W  = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // initiator 0
    input  logic        m0_wb_cyc_i,
    input  logic        m0_wb_stb_i,
    input  logic        m0_wb_we_i,
    input  logic [31:0] m0_wb_adr_i,
    input  logic [3:0]  m0_wb_sel_i,
    input  logic [31:0] m0_wb_dat_i,
    output logic [31:0] m0_wb_dat_o,
    output logic        m0_wb_ack_o,
    output logic        m0_wb_err_o,
    // initiator 1
    input  logic        m1_wb_cyc_i,
    input  logic        m1_wb_stb_i,
    input  logic        m1_wb_we_i,
    input  logic [31:0] m1_wb_adr_i,
    input  logic [3:0]  m1_wb_sel_i,
    input  logic [31:0] m1_wb_dat_i,
    output logic [31:0] m1_wb_dat_o,
    output logic        m1_wb_ack_o,
    output logic        m1_wb_err_o,
    // SRAM target
    output logic        s_wb_cyc_o,
    output logic        s_wb_stb_o,
    output logic        s_wb_we_o,
    output logic [31:0] s_wb_adr_o,
    output logic [3:0]  s_wb_sel_o,
    output logic [31:0] s_wb_dat_o,
    input  logic [31:0] s_wb_dat_i,
    input  logic        s_wb_ack_i,
    input  logic        s_wb_err_i,
    // status
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_last_grant;   // 1'b0 = m0 owned last, 1'b1 = m1 owned last
    logic       w_own_change;
    logic       w_owner_stb;
    logic       w_wdog_en;
    logic       w_fire;
    wb_req_t    w_m0_req;
    wb_req_t    w_m1_req;
    wb_req_t    w_own_req;

    assign w_m0_req = {m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i, m0_wb_adr_i, m0_wb_sel_i, m0_wb_dat_i};
    assign w_m1_req = {m1_wb_cyc_i, m1_wb_stb_i, m1_wb_we_i, m1_wb_adr_i, m1_wb_sel_i, m1_wb_dat_i};

    // Next-state logic: round-robin tie break from IDLE, hand-over without dead cycle
    always_comb begin
        w_next_state = WB_ARB_IDLE;
        case (r_state)
            WB_ARB_IDLE: begin
                if (m0_wb_cyc_i && m1_wb_cyc_i) begin
                    if (r_last_grant) begin
                        w_next_state = WB_ARB_OWN0;
                    end else begin
                        w_next_state = WB_ARB_OWN1;
                    end
                end else if (m0_wb_cyc_i) begin
                    w_next_state = WB_ARB_OWN0;
                end else if (m1_wb_cyc_i) begin
                    w_next_state = WB_ARB_OWN1;
                end else begin
                    w_next_state = WB_ARB_IDLE;
                end
            end
            WB_ARB_OWN0: begin
                if (m0_wb_cyc_i) begin
                    w_next_state = WB_ARB_OWN0;
                end else if (m1_wb_cyc_i) begin
                    w_next_state = WB_ARB_OWN1;
                end else begin
                    w_next_state = WB_ARB_IDLE;
                end
            end
            WB_ARB_OWN1: begin
                if (m1_wb_cyc_i) begin
                    w_next_state = WB_ARB_OWN1;
                end else if (m0_wb_cyc_i) begin
                    w_next_state = WB_ARB_OWN0;
                end else begin
                    w_next_state = WB_ARB_IDLE;
                end
            end
            default: begin
                w_next_state = WB_ARB_IDLE;
            end
        endcase
    end

    // State and last-owner registers; reset favours m0 on the first tie
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= WB_ARB_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == WB_ARB_OWN0) begin
                r_last_grant <= 1'b0;
            end else if (w_next_state == WB_ARB_OWN1) begin
                r_last_grant <= 1'b1;
            end else begin
                r_last_grant <= r_last_grant;
            end
        end
    end

    assign w_own_change = (w_next_state != r_state);

    // Select the owner's request; zero when idle so no X leaks to the SRAM
    always_comb begin
        w_own_req = wb_req_idle();
        case (r_state)
            WB_ARB_OWN0: w_own_req = w_m0_req;
            WB_ARB_OWN1: w_own_req = w_m1_req;
            default:     w_own_req = wb_req_idle();
        endcase
    end

    assign w_owner_stb = w_own_req.cyc & w_own_req.stb;

    // Stall detection: owner strobing with no response; the fire cycle counts as err
    assign w_wdog_en = w_owner_stb & ~w_fire & ~s_wb_ack_i & ~s_wb_err_i;

    wb_sram_rr_arbiter_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_CNT_W  (TIMEOUT_CNT_W)
    ) u_wdog (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .enable (w_wdog_en),
        .clear  (w_own_change),
        .fire_o (w_fire)
    );

    // Drive the SRAM side; strobe is withdrawn in the watchdog fire cycle
    always_comb begin
        s_wb_cyc_o = w_own_req.cyc;
        s_wb_stb_o = w_owner_stb & ~w_fire;
        s_wb_we_o  = w_own_req.we;
        s_wb_adr_o = w_own_req.adr;
        s_wb_sel_o = w_own_req.sel;
        s_wb_dat_o = w_own_req.dat;
    end

    // Route the response to the owner only; forced err suppresses a late ack
    always_comb begin
        m0_wb_dat_o = 32'd0;
        m0_wb_ack_o = 1'b0;
        m0_wb_err_o = 1'b0;
        m1_wb_dat_o = 32'd0;
        m1_wb_ack_o = 1'b0;
        m1_wb_err_o = 1'b0;
        case (r_state)
            WB_ARB_OWN0: begin
                m0_wb_dat_o = s_wb_dat_i;
                m0_wb_ack_o = s_wb_ack_i & ~w_fire;
                m0_wb_err_o = s_wb_err_i | w_fire;
            end
            WB_ARB_OWN1: begin
                m1_wb_dat_o = s_wb_dat_i;
                m1_wb_ack_o = s_wb_ack_i & ~w_fire;
                m1_wb_err_o = s_wb_err_i | w_fire;
            end
            default: begin
                m0_wb_dat_o = 32'd0;
                m1_wb_dat_o = 32'd0;
            end
        endcase
    end

    assign grant_o   = state_to_grant(r_state);
    assign timeout_o = w_fire;

endmodule
